// File: rtl/axi_rmux_pkg.sv
// Shared types for the AXI read arbiter/mux: FSM state, AR control payload, index width helper.
package axi_rmux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Fixed-width AR control fields; ID/ADDR/USER are parameter-sized and handled separately.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } ar_payload_t;

    function automatic int IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    import axi_rmux_pkg::*;

    localparam int IW = IDX_W(N);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter_mux.sv
// N-master to 1-slave AXI4 read arbiter/mux, one burst outstanding, RLAST vs ARLEN checking.
// Define AXI_RMUX_PERF_EN to add per-master grant counters and an AR/R stall counter.
module axi_rd_arbiter_mux #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                                    ACLK,
    input  logic                                    ARESET,
    input  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]    m_ARID,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_ARADDR,
    input  logic [NUM_MASTERS-1:0][7:0]             m_ARLEN,
    input  logic [NUM_MASTERS-1:0][2:0]             m_ARSIZE,
    input  logic [NUM_MASTERS-1:0][1:0]             m_ARBURST,
    input  logic [NUM_MASTERS-1:0]                  m_ARLOCK,
    input  logic [NUM_MASTERS-1:0][3:0]             m_ARCACHE,
    input  logic [NUM_MASTERS-1:0][2:0]             m_ARPROT,
    input  logic [NUM_MASTERS-1:0][3:0]             m_ARQOS,
    input  logic [NUM_MASTERS-1:0][3:0]             m_ARREGION,
    input  logic [NUM_MASTERS-1:0][USER_WIDTH-1:0]  m_ARUSER,
    input  logic [NUM_MASTERS-1:0]                  m_ARVALID,
    output logic [NUM_MASTERS-1:0]                  m_ARREADY,
    output logic [NUM_MASTERS-1:0]                  m_RVALID,
    input  logic [NUM_MASTERS-1:0]                  m_RREADY,
    output logic [ID_WIDTH-1:0]                     m_RID,
    output logic [DATA_WIDTH-1:0]                   m_RDATA,
    output logic [1:0]                              m_RRESP,
    output logic                                    m_RLAST,
    output logic [ID_WIDTH-1:0]                     s_ARID,
    output logic [ADDR_WIDTH-1:0]                   s_ARADDR,
    output logic [7:0]                              s_ARLEN,
    output logic [2:0]                              s_ARSIZE,
    output logic [1:0]                              s_ARBURST,
    output logic                                    s_ARLOCK,
    output logic [3:0]                              s_ARCACHE,
    output logic [2:0]                              s_ARPROT,
    output logic [3:0]                              s_ARQOS,
    output logic [3:0]                              s_ARREGION,
    output logic [USER_WIDTH-1:0]                   s_ARUSER,
    output logic                                    s_ARVALID,
    input  logic                                    s_ARREADY,
    input  logic [ID_WIDTH-1:0]                     s_RID,
    input  logic [DATA_WIDTH-1:0]                   s_RDATA,
    input  logic [1:0]                              s_RRESP,
    input  logic                                    s_RLAST,
    input  logic                                    s_RVALID,
    output logic                                    s_RREADY,
    output logic [$clog2(NUM_MASTERS)-1:0]          grant_idx,
    output logic                                    busy,
    output logic                                    len_err
`ifdef AXI_RMUX_PERF_EN
    ,
    output logic [NUM_MASTERS-1:0][31:0]            perf_grant_cnt,
    output logic [31:0]                             perf_stall_cnt
`endif
);
    import axi_rmux_pkg::*;

    localparam int IW = IDX_W(NUM_MASTERS);

    state_t                 state;
    logic [IW-1:0]          grant;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          arb_idx;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic                   arb_any;
    logic [7:0]             beat_cnt;
    logic [7:0]             alen;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   cnt_hit;
    logic                   burst_end;
    ar_payload_t            sel;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req (m_ARVALID),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_any = |arb_gnt;

    assign sel = '{
        len:    m_ARLEN[grant],
        size:   m_ARSIZE[grant],
        burst:  m_ARBURST[grant],
        lock:   m_ARLOCK[grant],
        cache:  m_ARCACHE[grant],
        prot:   m_ARPROT[grant],
        qos:    m_ARQOS[grant],
        region: m_ARREGION[grant]
    };

    // Only the owner sees ready/valid; every other master is held off.
    always_comb begin
        s_ARVALID = 1'b0;
        m_ARREADY = '0;
        s_ARID    = '0;
        s_ARADDR  = '0;
        s_ARUSER  = '0;
        {s_ARLEN, s_ARSIZE, s_ARBURST, s_ARLOCK,
         s_ARCACHE, s_ARPROT, s_ARQOS, s_ARREGION} = '0;
        s_RREADY  = 1'b0;
        m_RVALID  = '0;
        case (state)
            ADDR: begin
                s_ARVALID        = m_ARVALID[grant];
                m_ARREADY[grant] = s_ARREADY;
                s_ARID           = m_ARID[grant];
                s_ARADDR         = m_ARADDR[grant];
                s_ARUSER         = m_ARUSER[grant];
                {s_ARLEN, s_ARSIZE, s_ARBURST, s_ARLOCK,
                 s_ARCACHE, s_ARPROT, s_ARQOS, s_ARREGION} = sel;
            end
            DATA: begin
                m_RVALID[grant] = s_RVALID;
                s_RREADY        = m_RREADY[grant];
            end
            default: ;
        endcase
    end

    assign m_RID   = s_RID;
    assign m_RDATA = s_RDATA;
    assign m_RRESP = s_RRESP;
    assign m_RLAST = s_RLAST;

    assign ar_hs     = s_ARVALID & s_ARREADY;
    assign r_hs      = s_RVALID & s_RREADY;
    assign cnt_hit   = (beat_cnt == alen);
    assign burst_end = r_hs & (s_RLAST | cnt_hit);

    assign grant_idx = grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            rr_ptr  <= IW'(NUM_MASTERS - 1);
            grant   <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant  <= arb_idx;
                        rr_ptr <= arb_idx;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        alen     <= m_ARLEN[grant];
                        beat_cnt <= 8'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    // Either terminating condition ends the burst; disagreement is a length error.
                    if (burst_end) begin
                        state <= IDLE;
                        if (s_RLAST ^ cnt_hit) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_RMUX_PERF_EN
    logic stall;

    assign stall = ((state == ADDR) & s_ARVALID & ~s_ARREADY) |
                   ((state == DATA) & s_RVALID & ~s_RREADY);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if ((state == IDLE) && arb_any) begin
                perf_grant_cnt[arb_idx] <= perf_grant_cnt[arb_idx] + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter_mux.sv
// Directed bench for axi_rd_arbiter_mux with four masters: per-cycle vector table plus burst sequences.
module tb_axi_rd_arbiter_mux;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int UW = 1;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1000_0100;
    localparam logic [31:0] A2 = 32'h1000_0200;
    localparam logic [31:0] A3 = 32'h1000_0300;

    logic                      ACLK = 1'b0;
    logic                      ARESET;
    logic [N-1:0][IW-1:0]      m_ARID;
    logic [N-1:0][AW-1:0]      m_ARADDR;
    logic [N-1:0][7:0]         m_ARLEN;
    logic [N-1:0][2:0]         m_ARSIZE;
    logic [N-1:0][1:0]         m_ARBURST;
    logic [N-1:0]              m_ARLOCK;
    logic [N-1:0][3:0]         m_ARCACHE;
    logic [N-1:0][2:0]         m_ARPROT;
    logic [N-1:0][3:0]         m_ARQOS;
    logic [N-1:0][3:0]         m_ARREGION;
    logic [N-1:0][UW-1:0]      m_ARUSER;
    logic [N-1:0]              m_ARVALID;
    logic [N-1:0]              m_ARREADY;
    logic [N-1:0]              m_RVALID;
    logic [N-1:0]              m_RREADY;
    logic [IW-1:0]             m_RID;
    logic [DW-1:0]             m_RDATA;
    logic [1:0]                m_RRESP;
    logic                      m_RLAST;
    logic [IW-1:0]             s_ARID;
    logic [AW-1:0]             s_ARADDR;
    logic [7:0]                s_ARLEN;
    logic [2:0]                s_ARSIZE;
    logic [1:0]                s_ARBURST;
    logic                      s_ARLOCK;
    logic [3:0]                s_ARCACHE;
    logic [2:0]                s_ARPROT;
    logic [3:0]                s_ARQOS;
    logic [3:0]                s_ARREGION;
    logic [UW-1:0]             s_ARUSER;
    logic                      s_ARVALID;
    logic                      s_ARREADY;
    logic [IW-1:0]             s_RID;
    logic [DW-1:0]             s_RDATA;
    logic [1:0]                s_RRESP;
    logic                      s_RLAST;
    logic                      s_RVALID;
    logic                      s_RREADY;
    logic [1:0]                grant_idx;
    logic                      busy;
    logic                      len_err;

    axi_rd_arbiter_mux #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW),
        .USER_WIDTH  (UW)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .m_ARID     (m_ARID),
        .m_ARADDR   (m_ARADDR),
        .m_ARLEN    (m_ARLEN),
        .m_ARSIZE   (m_ARSIZE),
        .m_ARBURST  (m_ARBURST),
        .m_ARLOCK   (m_ARLOCK),
        .m_ARCACHE  (m_ARCACHE),
        .m_ARPROT   (m_ARPROT),
        .m_ARQOS    (m_ARQOS),
        .m_ARREGION (m_ARREGION),
        .m_ARUSER   (m_ARUSER),
        .m_ARVALID  (m_ARVALID),
        .m_ARREADY  (m_ARREADY),
        .m_RVALID   (m_RVALID),
        .m_RREADY   (m_RREADY),
        .m_RID      (m_RID),
        .m_RDATA    (m_RDATA),
        .m_RRESP    (m_RRESP),
        .m_RLAST    (m_RLAST),
        .s_ARID     (s_ARID),
        .s_ARADDR   (s_ARADDR),
        .s_ARLEN    (s_ARLEN),
        .s_ARSIZE   (s_ARSIZE),
        .s_ARBURST  (s_ARBURST),
        .s_ARLOCK   (s_ARLOCK),
        .s_ARCACHE  (s_ARCACHE),
        .s_ARPROT   (s_ARPROT),
        .s_ARQOS    (s_ARQOS),
        .s_ARREGION (s_ARREGION),
        .s_ARUSER   (s_ARUSER),
        .s_ARVALID  (s_ARVALID),
        .s_ARREADY  (s_ARREADY),
        .s_RID      (s_RID),
        .s_RDATA    (s_RDATA),
        .s_RRESP    (s_RRESP),
        .s_RLAST    (s_RLAST),
        .s_RVALID   (s_RVALID),
        .s_RREADY   (s_RREADY),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .len_err    (len_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [3:0]  arv;
        logic [7:0]  len;
        logic        sarr;
        logic        srv;
        logic        slast;
        logic [3:0]  rrdy;
        logic        sarv;
        logic [3:0]  arr;
        logic [3:0]  rv;
        logic        srr;
        logic [1:0]  gidx;
        logic        busy;
        logic        lerr;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_len(input logic [7:0] l);
        for (int i = 0; i < N; i++) m_ARLEN[i] = l;
    endtask

    function automatic logic [63:0] exp_pl(input int i);
        return 64'({m_ARID[i], m_ARLEN[i], m_ARSIZE[i], m_ARBURST[i], m_ARLOCK[i],
                    m_ARCACHE[i], m_ARPROT[i], m_ARQOS[i], m_ARREGION[i], m_ARUSER[i]});
    endfunction

    function automatic logic [63:0] act_pl();
        return 64'({s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARLOCK,
                    s_ARCACHE, s_ARPROT, s_ARQOS, s_ARREGION, s_ARUSER});
    endfunction

    // One complete burst with every master ready: records owner, owner beats, stray beats, R-path errors.
    task automatic burst(input logic [7:0] len, output int g, output int own,
                         output int other, output int dbad);
        int n;
        g = -1; own = 0; other = 0; dbad = 0; n = 0;
        @(negedge ACLK);
        set_len(len);
        s_ARREADY = 1'b1;
        m_RREADY  = '1;
        #1;
        while (!s_ARVALID && n < 20) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        if (!s_ARVALID) begin
            chk("arvalid_wait", 64'(s_ARVALID), 64'd1);
            return;
        end
        g = int'(grant_idx);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge ACLK);
            s_RVALID = 1'b1;
            s_RLAST  = (b == int'(len));
            s_RDATA  = 32'hD000_0000 + 32'(b);
            s_RRESP  = 2'(b);
            #1;
            if (m_RVALID == 4'(1 << g)) own++;
            else other++;
            if (m_RDATA !== s_RDATA || m_RLAST !== s_RLAST || m_RRESP !== s_RRESP) dbad++;
        end
        @(negedge ACLK);
        s_RVALID = 1'b0;
        s_RLAST  = 1'b0;
        #1;
        chk("burst_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [45:0] obs;
        logic [45:0] expv;
        int g, own, other, dbad;
        int exp_g [4] = '{0, 1, 0, 1};

        ARESET    = 1'b1;
        m_ARVALID = '0;
        m_RREADY  = '0;
        s_ARREADY = 1'b0;
        s_RVALID  = 1'b0;
        s_RLAST   = 1'b0;
        s_RID     = '0;
        s_RDATA   = '0;
        s_RRESP   = '0;
        for (int i = 0; i < N; i++) begin
            m_ARID[i]     = 1'(i);
            m_ARADDR[i]   = A0 + 32'(i) * 32'h100;
            m_ARLEN[i]    = 8'd0;
            m_ARSIZE[i]   = 3'(i + 1);
            m_ARBURST[i]  = 2'b01;
            m_ARLOCK[i]   = (i == 3);
            m_ARCACHE[i]  = 4'(i + 3);
            m_ARPROT[i]   = 3'(i);
            m_ARQOS[i]    = 4'(8 + i);
            m_ARREGION[i] = 4'(i * 2);
            m_ARUSER[i]   = 1'(i >> 1);
        end

        //           arv      len   sarr  srv   slast rrdy    | sarv  arr      rv       srr   gidx  busy  lerr  addr
        vt[0]  = '{4'b0011, 8'd3, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{4'b0011, 8'd3, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, A0};
        vt[2]  = '{4'b0011, 8'd3, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, A0};
        vt[3]  = '{4'b0011, 8'd3, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{4'b0011, 8'd3, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[5]  = '{4'b0011, 8'd3, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{4'b0011, 8'd3, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{4'b0011, 8'd3, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{4'b0011, 8'd3, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{4'b0011, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        vt[10] = '{4'b0011, 8'd1, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, A1};
        vt[11] = '{4'b0011, 8'd1, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0};
        vt[12] = '{4'b0000, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0};
        vt[13] = '{4'b0000, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0};
        vt[14] = '{4'b0100, 8'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0};
        vt[15] = '{4'b0000, 8'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, A2};
        vt[16] = '{4'b0100, 8'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, A2};
        vt[17] = '{4'b0000, 8'd2, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 32'h0};
        vt[18] = '{4'b0000, 8'd2, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 32'h0};
        vt[19] = '{4'b0000, 8'd2, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 32'h0};
        vt[20] = '{4'b1001, 8'd2, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b1, 32'h0};
        vt[21] = '{4'b1001, 8'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, A3};

        @(negedge ACLK);
        @(negedge ACLK);
        #1;
        chk("reset_state",
            64'({s_ARVALID, m_ARREADY, m_RVALID, s_RREADY, grant_idx, busy, len_err}),
            64'd0);
        chk("reset_ar_payload", act_pl() | 64'(s_ARADDR), 64'd0);

        for (int k = 0; k < NV; k++) begin
            @(negedge ACLK);
            ARESET    = 1'b0;
            m_ARVALID = vt[k].arv;
            set_len(vt[k].len);
            s_ARREADY = vt[k].sarr;
            s_RVALID  = vt[k].srv;
            s_RLAST   = vt[k].slast;
            m_RREADY  = vt[k].rrdy;
            #1;
            obs  = {s_ARVALID, m_ARREADY, m_RVALID, s_RREADY, grant_idx, busy, len_err, s_ARADDR};
            expv = {vt[k].sarv, vt[k].arr, vt[k].rv, vt[k].srr, vt[k].gidx,
                    vt[k].busy, vt[k].lerr, vt[k].addr};
            chk($sformatf("vec%0d", k), 64'(obs), 64'(expv));
        end

        // Reset clears the sticky error; lone requester m3 is granted and its ready stalls propagate.
        @(negedge ACLK);
        ARESET    = 1'b1;
        m_ARVALID = '0;
        s_ARREADY = 1'b0;
        s_RVALID  = 1'b0;
        s_RLAST   = 1'b0;
        m_RREADY  = '0;
        @(negedge ACLK);
        ARESET    = 1'b0;
        m_ARVALID = 4'b1000;
        set_len(8'd5);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        @(negedge ACLK);
        s_ARREADY = 1'b1;
        #1;
        chk("m3_grant_idx", 64'(grant_idx), 64'd3);
        chk("m3_arvalid", 64'(s_ARVALID), 64'd1);
        chk("m3_arready", 64'(m_ARREADY), 64'b1000);
        chk("m3_araddr", 64'(s_ARADDR), 64'(A3));
        chk("m3_payload", act_pl(), exp_pl(3));
        @(negedge ACLK);
        s_ARREADY = 1'b0;
        s_RVALID  = 1'b1;
        m_RREADY  = 4'b0111;
        #1;
        chk("m3_rvalid", 64'(m_RVALID), 64'b1000);
        chk("m3_rready_stall", 64'(s_RREADY), 64'd0);
        @(negedge ACLK);
        m_RREADY = 4'b1000;
        #1;
        chk("m3_rready_go", 64'(s_RREADY), 64'd1);
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET    = 1'b0;
        m_ARVALID = 4'b1111;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rvalid", 64'(m_RVALID), 64'd0);
        chk("mid_rst_rready", 64'(s_RREADY), 64'd0);
        @(negedge ACLK);
        #1;
        chk("post_rst_grant", 64'(grant_idx), 64'd0);
        chk("post_rst_araddr", 64'(s_ARADDR), 64'(A0));
        chk("post_rst_payload", act_pl(), exp_pl(0));

        // Fresh reset, masters 0 and 1 requesting continuously: four 4-beat bursts alternate owners.
        @(negedge ACLK);
        ARESET    = 1'b1;
        m_ARVALID = '0;
        s_RVALID  = 1'b0;
        @(negedge ACLK);
        ARESET    = 1'b0;
        m_ARVALID = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            burst(8'd3, g, own, other, dbad);
            chk($sformatf("rr_grant%0d", b), 64'(g), 64'(exp_g[b]));
            chk($sformatf("rr_beats%0d", b), 64'(own), 64'd4);
            chk($sformatf("rr_stray%0d", b), 64'(other + dbad), 64'd0);
        end
        chk("rr_len_err", 64'(len_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
